// File: rtl/ann_sched_pkg.sv
// Shared definitions for the ANN layer scheduler: FSM state encoding, layer
// identifiers and default group counts.
package ann_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic LAYER_HID = 1'b0;
  localparam logic LAYER_OUT = 1'b1;

  localparam int unsigned DEF_HID_GROUPS = 8;
  localparam int unsigned DEF_OUT_GROUPS = 2;

endpackage

// File: rtl/sched_watchdog.sv
// WAIT-phase timeout counter: cleared while a group is issued, advanced each
// WAIT cycle, flags expiry on the TIMEOUT-th consecutive WAIT cycle.
module sched_watchdog #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // cnt_q holds the WAIT cycles already completed, so the current one is cnt_q+1
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ann_layer_scheduler.sv
// Time-shares one neuron PE over all hidden-layer then output-layer groups.
// Define ANN_SCHED_WATCHDOG_EN to add the WAIT timeout and the ERR state.
module ann_layer_scheduler
  import ann_sched_pkg::*;
#(
  parameter int unsigned HID_GROUPS = DEF_HID_GROUPS,
  parameter int unsigned OUT_GROUPS = DEF_OUT_GROUPS,
  parameter int unsigned GROUP_W    = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TO_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               load_data,
  output logic               pe_start,
  output logic               pe_layer,
  output logic [GROUP_W-1:0] pe_group,
  input  logic               pe_ready,
  output logic               received,
  output logic               wr_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  if (HID_GROUPS < 1 || OUT_GROUPS < 1 ||
      HID_GROUPS > (1 << GROUP_W) || OUT_GROUPS > (1 << GROUP_W)) begin : g_bad_groups
    $error("ann_layer_scheduler: group counts do not fit GROUP_W");
  end
  if (TO_W < 1 || TIMEOUT < 1 || TIMEOUT > (1 << TO_W)) begin : g_bad_timeout
    $error("ann_layer_scheduler: TIMEOUT does not fit TO_W");
  end

  localparam logic [GROUP_W-1:0] HID_LAST = GROUP_W'(HID_GROUPS - 1);
  localparam logic [GROUP_W-1:0] OUT_LAST = GROUP_W'(OUT_GROUPS - 1);

  state_e             state_q, state_d;
  logic               layer_q, layer_d;
  logic [GROUP_W-1:0] group_q, group_d;
  logic [GROUP_W-1:0] group_last;
  logic               wd_expired;

`ifdef ANN_SCHED_WATCHDOG_EN
  sched_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (state_q == ST_ISSUE),
    .en_i      (state_q == ST_WAIT),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      layer_q <= LAYER_HID;
      group_q <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      group_q <= group_d;
    end
  end

  assign group_last = (layer_q == LAYER_OUT) ? OUT_LAST : HID_LAST;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    group_d = group_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        layer_d = LAYER_HID;
        group_d = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // A ready PE takes priority over a timeout in the same cycle
        if (pe_ready)        state_d = ST_ACK;
        else if (wd_expired) state_d = ST_ERR;
      end
      ST_ACK: begin
        if (group_q != group_last) begin
          group_d = group_q + GROUP_W'(1);
          state_d = ST_ISSUE;
        end else if (layer_q == LAYER_HID) begin
          layer_d = LAYER_OUT;
          group_d = '0;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        if (start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_data = 1'b0;
    pe_start  = 1'b0;
    received  = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        load_data = 1'b1;
        busy      = 1'b1;
      end
      ST_ISSUE: begin
        pe_start = 1'b1;
        busy     = 1'b1;
      end
      ST_WAIT: busy = 1'b1;
      ST_ACK: begin
        received = 1'b1;
        wr_en    = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ANN_SCHED_WATCHDOG_EN
  assign err = (state_q == ST_ERR);
`else
  assign err = 1'b0;
`endif

  assign pe_layer = layer_q;
  assign pe_group = group_q;

endmodule
